// File: rtl/wrapper_ram_banked.sv
// Word-banked multi-port cache-line RAM with programmer override.
// Define RAM_RR_ARB_EN for round-robin arbitration; RAM_SIM_INIT zero-fills the banks in sim.
module wrapper_ram_banked #(
  parameter int WORD_WIDTH       = 32,
  parameter int RAM_DEPTH        = 32768,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int NUM_PORTS        = 2,
  localparam int ADDR_W = $clog2(RAM_DEPTH),
  localparam int WPL    = CACHE_LINE_WIDTH / WORD_WIDTH,
  localparam int LB     = $clog2(WPL),
  localparam int STRB_W = CACHE_LINE_WIDTH / 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [NUM_PORTS-1:0]                         req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]             addr_i,
  input  logic [NUM_PORTS-1:0][CACHE_LINE_WIDTH-1:0]   wdata_i,
  input  logic [NUM_PORTS-1:0][STRB_W-1:0]             wstrb_i,
  output logic [NUM_PORTS-1:0]                         gnt_o,
  output logic [NUM_PORTS-1:0][CACHE_LINE_WIDTH-1:0]   rdata_o,
  output logic [NUM_PORTS-1:0]                         rvalid_o,
  input  logic                                         prog_valid_i,
  input  logic [ADDR_W-1:0]                            prog_addr_i,
  input  logic [WORD_WIDTH-1:0]                        prog_data_i,
  input  logic                                         prog_mode_i
);

  localparam int ROWS  = RAM_DEPTH / WPL;
  localparam int ROW_W = ADDR_W - LB;
  localparam int BPW   = WORD_WIDTH / 8;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef struct packed {
    logic                        vld;
    logic [PW-1:0]               port;
  } rd_s1_t;

  logic [WORD_WIDTH-1:0] mem [WPL][ROWS];

  logic                        blk;
  logic [PW-1:0]               sel;
  logic                        acc;
  logic [ADDR_W-1:0]           a;
  logic [CACHE_LINE_WIDTH-1:0] wd;
  logic [STRB_W-1:0]           ws;
  logic [ROW_W-1:0]            row;
  logic                        wr;
  logic                        rd;
  logic [LB-1:0]               prog_bank;
  logic [ROW_W-1:0]            prog_row;
  rd_s1_t                      s1;
  logic [CACHE_LINE_WIDTH-1:0] s1_line;
  logic                        unused;

  assign blk = rst_i | prog_mode_i | prog_valid_i;

`ifdef RAM_RR_ARB_EN
  logic [PW-1:0] ptr;
  logic          found;
  int            idx;

  // Search starts just after the last granted port and wraps.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (req_i[idx] && !found) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= PW'(NUM_PORTS - 1);
    end else if (acc) begin
      ptr <= sel;
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_i[i]) sel = PW'(i);
    end
  end
`endif

  always_comb begin
    gnt_o = '0;
    if (!blk && |req_i) gnt_o[sel] = 1'b1;
  end

  assign acc = |gnt_o;
  assign a   = addr_i[sel];
  assign wd  = wdata_i[sel];
  assign ws  = wstrb_i[sel];
  assign row = a[ADDR_W-1:LB];
  assign wr  = acc & (|ws);
  assign rd  = acc & ~(|ws);

  assign prog_bank = prog_addr_i[LB-1:0];
  assign prog_row  = prog_addr_i[ADDR_W-1:LB];

  // Line requests are line aligned; word offset bits are dropped.
  assign unused = ^a[LB-1:0];

  always_ff @(posedge clk_i) begin
    if (prog_valid_i) begin
      mem[prog_bank][prog_row] <= prog_data_i;
    end else if (wr) begin
      for (int b = 0; b < WPL; b++) begin
        for (int y = 0; y < BPW; y++) begin
          if (ws[b*BPW+y]) begin
            mem[b][row][y*8 +: 8] <= wd[b*WORD_WIDTH + y*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd) begin
      for (int b = 0; b < WPL; b++) begin
        s1_line[b*WORD_WIDTH +: WORD_WIDTH] <= mem[b][row];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= '0;
    end else begin
      s1.vld  <= rd;
      s1.port <= sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= '0;
      if (s1.vld) begin
        rvalid_o[s1.port] <= 1'b1;
        rdata_o[s1.port]  <= s1_line;
      end
    end
  end

`ifdef RAM_SIM_INIT
  initial begin
    for (int w = 0; w < RAM_DEPTH; w++) begin
      mem[w % WPL][w / WPL] = '0;
    end
  end
`endif

endmodule

// File: tb/tb_wrapper_ram_banked.sv
// Scoreboard bench for wrapper_ram_banked: directed stimulus,
// decoupled read-response monitor.
module tb_wrapper_ram_banked;

  localparam int AW = 15;
  localparam int LW = 128;
  localparam int SW = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [1:0]             req_i;
  logic [1:0][AW-1:0]     addr_i;
  logic [1:0][LW-1:0]     wdata_i;
  logic [1:0][SW-1:0]     wstrb_i;
  logic [1:0]             gnt_o;
  logic [1:0][LW-1:0]     rdata_o;
  logic [1:0]             rvalid_o;
  logic                   prog_valid_i;
  logic [AW-1:0]          prog_addr_i;
  logic [31:0]            prog_data_i;
  logic                   prog_mode_i;

  typedef struct {
    logic [LW-1:0] data;
    int            due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  localparam logic [LW-1:0] L0 = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
  localparam logic [LW-1:0] L1 = {32'h1007, 32'h1006, 32'h1005, 32'h1004};
  localparam logic [LW-1:0] L2 = {32'h100B, 32'h100A, 32'hDEADBEEF, 32'h1008};
  localparam logic [LW-1:0] L3 = {32'h100F, 32'h100E, 32'hCAFE0013, 32'h100C};

  wrapper_ram_banked dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .wstrb_i      (wstrb_i),
    .gnt_o        (gnt_o),
    .rdata_o      (rdata_o),
    .rvalid_o     (rvalid_o),
    .prog_valid_i (prog_valid_i),
    .prog_addr_i  (prog_addr_i),
    .prog_data_i  (prog_data_i),
    .prog_mode_i  (prog_mode_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic push(input int p, input logic [LW-1:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 2;
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon_port(input int p);
    exp_t e;
    logic empty;
    total++;
    empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      $display("FAIL rvalid_p%0d: got unexpected pulse at cycle %0d expected none",
               p, cyc);
    end else begin
      if (p == 0) e = q0.pop_front();
      else e = q1.pop_front();
      if (rdata_o[p] !== e.data || cyc != e.due)
        $display("FAIL rdata_p%0d: got %h at cycle %0d expected %h at cycle %0d",
                 p, rdata_o[p], cyc, e.data, e.due);
      else
        passed++;
    end
  endtask

  always @(negedge clk_i) begin
    if (rvalid_o[0]) mon_port(0);
    if (rvalid_o[1]) mon_port(1);
  end

  initial begin
    logic [1:0]    eg;
    logic [AW-1:0] t6a [3];
    logic [LW-1:0] t6d [3];
    rst_i        = 1'b1;
    req_i        = '0;
    addr_i       = '0;
    wdata_i      = '0;
    wstrb_i      = '0;
    prog_valid_i = 1'b0;
    prog_addr_i  = '0;
    prog_data_i  = '0;
    prog_mode_i  = 1'b0;
    tick(); tick(); tick();
    @(negedge clk_i);
    chk("rst_rvalid", LW'(rvalid_o), '0);
    chk("rst_rdata0", rdata_o[0], '0);
    chk("rst_rdata1", rdata_o[1], '0);
    tick();
    rst_i = 1'b0;
    tick();

    // 1: program words 0..15, read line at addr 4
    for (int i = 0; i < 16; i++) begin
      prog_valid_i = 1'b1;
      prog_addr_i  = AW'(i);
      prog_data_i  = 32'h1000 + i;
      tick();
    end
    prog_valid_i = 1'b0;
    req_i[0]  = 1'b1;
    addr_i[0] = 15'd4;
    @(negedge clk_i);
    chk("t1_gnt", LW'(gnt_o), LW'(2'b01));
    push(0, L1);
    tick();
    req_i = '0;
    tick(); tick(); tick();

    // 2: partial write of word1 on port1, then read back
    req_i[1]   = 1'b1;
    addr_i[1]  = 15'd8;
    wdata_i[1] = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEADBEEF, 32'hFFFF_FFFF};
    wstrb_i[1] = 16'h00F0;
    @(negedge clk_i);
    chk("t2_wr_gnt", LW'(gnt_o), LW'(2'b10));
    tick();
    wstrb_i[1] = '0;
    wdata_i[1] = '0;
    @(negedge clk_i);
    chk("t2_rd_gnt", LW'(gnt_o), LW'(2'b10));
    push(1, L2);
    tick();
    req_i = '0;
    tick(); tick(); tick();

    // 3: contention for 6 cycles
    req_i     = 2'b11;
    addr_i[0] = 15'd0;
    addr_i[1] = 15'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
`ifdef RAM_RR_ARB_EN
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      eg = 2'b01;
`endif
      chk($sformatf("t3_gnt%0d", k), LW'(gnt_o), LW'(eg));
      if (gnt_o[0]) push(0, L0);
      if (gnt_o[1]) push(1, L1);
      tick();
    end
    req_i = '0;
    tick(); tick(); tick();

    // 4: programmer write blocks the port for one cycle
    req_i[0]     = 1'b1;
    addr_i[0]    = 15'd12;
    prog_valid_i = 1'b1;
    prog_addr_i  = 15'd13;
    prog_data_i  = 32'hCAFE0013;
    @(negedge clk_i);
    chk("t4_gnt_blocked", LW'(gnt_o), '0);
    tick();
    prog_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t4_gnt_after", LW'(gnt_o), LW'(2'b01));
    push(0, L3);
    tick();
    req_i = '0;
    tick(); tick(); tick();

    // 5: reset right after a read accept drops the response
    req_i[0]  = 1'b1;
    addr_i[0] = 15'd0;
    @(negedge clk_i);
    chk("t5_gnt", LW'(gnt_o), LW'(2'b01));
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5_gnt_in_rst", LW'(gnt_o), '0);
    tick(); tick();
    rst_i     = 1'b0;
    req_i     = 2'b11;
    addr_i[0] = 15'd4;
    addr_i[1] = 15'd8;
    @(negedge clk_i);
    chk("t5_rdata0_cleared", rdata_o[0], '0);
    chk("t5_first_gnt", LW'(gnt_o), LW'(2'b01));
    push(0, L1);
    tick();
    req_i[0] = 1'b0;
    @(negedge clk_i);
    chk("t5_p1_gnt", LW'(gnt_o), LW'(2'b10));
    push(1, L2);
    tick();
    req_i = '0;
    tick(); tick(); tick();

    // 6: back-to-back reads of lines 0,1,2 with unaligned addresses
    t6a[0] = 15'd1;  t6d[0] = L0;
    t6a[1] = 15'd6;  t6d[1] = L1;
    t6a[2] = 15'd11; t6d[2] = L2;
    req_i[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr_i[0] = t6a[k];
      @(negedge clk_i);
      chk($sformatf("t6_gnt%0d", k), LW'(gnt_o), LW'(2'b01));
      push(0, t6d[k]);
      tick();
    end
    req_i = '0;
    for (int k = 0; k < 6; k++) tick();

    chk("q0_drained", LW'(q0.size()), '0);
    chk("q1_drained", LW'(q1.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
